// File: rtl/debounce_pkg.sv
// Shared debounce defaults and the counter-width legality check.
// No logic; constants and a constant function only.
package debounce_pkg;

   localparam int unsigned DEF_STABLE_CYCLES = 50000;
   localparam int unsigned DEF_CNT_W         = 16;

   // True when STABLE_CYCLES is at least 2 and STABLE_CYCLES-1 is reachable without wrapping.
   function automatic bit stable_fits(input int unsigned stable, input int unsigned cnt_w);
      return (stable >= 2) && ($clog2(stable + 1) <= cnt_w);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, qualify counter, debounced level, edge pulses.
// Latency 2+STABLE_CYCLES cycles from input step to o_state; no backpressure, pulses last one cycle.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W,
   parameter logic        INIT          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic o_state,
   output logic o_press,
   output logic o_release
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt_q;
   logic             differs;
   logic             flip;

   assign differs = (sync_q2 != o_state);
   assign flip    = differs && (cnt_q == LAST);

   // Synchronisers reset to INIT so reset release never looks like a transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1   <= INIT;
         sync_q2   <= INIT;
         cnt_q     <= '0;
         o_state   <= INIT;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         sync_q1   <= btn;
         sync_q2   <= sync_q1;
         if (!differs || flip) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (flip) begin
            o_state <= ~o_state;
         end
         o_press   <= flip & ~o_state;
         o_release <= flip &  o_state;
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels plus optional sticky pending/IRQ (macro DEBOUNCE_IRQ_EN).
// Latency 2+STABLE_CYCLES cycles per channel; no backpressure, pending flags hold until i_clr.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned N             = 4,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEF_CNT_W,
   parameter logic [N-1:0] INIT         = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] i_btn,
   input  logic [N-1:0] i_clr,
   output logic [N-1:0] o_state,
   output logic [N-1:0] o_press,
   output logic [N-1:0] o_release,
   output logic [N-1:0] o_pending,
   output logic         o_irq
);

   generate
      if (!stable_fits(STABLE_CYCLES, CNT_W)) begin : g_bad_stable
         $error("debounce_multi: STABLE_CYCLES must be in 2..2**CNT_W-1");
      end
      if (N < 1 || N > 32) begin : g_bad_n
         $error("debounce_multi: N must be in 1..32");
      end
   endgenerate

   for (genvar i = 0; i < N; i++) begin : g_chan
      debounce_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W),
         .INIT          (INIT[i])
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn       (i_btn[i]),
         .o_state   (o_state[i]),
         .o_press   (o_press[i]),
         .o_release (o_release[i])
      );
   end

`ifdef DEBOUNCE_IRQ_EN
   logic [N-1:0] pending_q;

   // A pulse arriving with a clear keeps the flag set so no edge is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~i_clr) | o_press | o_release;
      end
   end

   assign o_pending = pending_q;
   assign o_irq     = |pending_q;
`else
   logic unused_clr;

   assign unused_clr = ^i_clr;
   assign o_pending  = '0;
   assign o_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed vector bench for debounce_multi with N=2, STABLE_CYCLES=4, CNT_W=4, INIT=0.
module tb_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_btn;
   logic [1:0] i_clr;
   logic [1:0] o_state;
   logic [1:0] o_press;
   logic [1:0] o_release;
   logic [1:0] o_pending;
   logic       o_irq;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst_n;
      logic [1:0] btn;
      logic [1:0] clr;
      logic [1:0] st;
      logic [1:0] pr;
      logic [1:0] rl;
      logic [1:0] pd;
   } vec_t;

   vec_t vecs[$];

   debounce_multi #(
      .N             (2),
      .STABLE_CYCLES (4),
      .CNT_W         (4),
      .INIT          (2'b00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_btn     (i_btn),
      .i_clr     (i_clr),
      .o_state   (o_state),
      .o_press   (o_press),
      .o_release (o_release),
      .o_pending (o_pending),
      .o_irq     (o_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] pexp(input logic [1:0] d);
`ifdef DEBOUNCE_IRQ_EN
      return d;
`else
      return 2'b00;
`endif
   endfunction

   task automatic add(input logic r, input logic [1:0] b, input logic [1:0] c,
                      input logic [1:0] s, input logic [1:0] p, input logic [1:0] l,
                      input logic [1:0] d);
      vec_t v;
      v.rst_n = r; v.btn = b; v.clr = c; v.st = s; v.pr = p; v.rl = l; v.pd = d;
      vecs.push_back(v);
   endtask

   task automatic idle(input int n, input logic [1:0] b, input logic [1:0] s, input logic [1:0] d);
      repeat (n) add(1'b1, b, 2'b00, s, 2'b00, 2'b00, d);
   endtask

   initial begin
      int n;

      // Single-cycle glitch on ch0: nothing may happen.
      add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(8, 2'b00, 2'b00, 2'b00);
      // Glitch one sync cycle short of qualifying.
      repeat (3) add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(6, 2'b00, 2'b00, 2'b00);
      // Clean press on ch0: state rises on the 6th edge.
      idle(5, 2'b01, 2'b00, 2'b00);
      add(1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      idle(3, 2'b01, 2'b01, 2'b01);
      // Release on ch0; clear collides with the release pulse, then clear alone.
      idle(5, 2'b00, 2'b01, 2'b01);
      add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
      add(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(2, 2'b00, 2'b00, 2'b00);
      // Both channels together.
      idle(5, 2'b11, 2'b00, 2'b00);
      add(1'b1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
      idle(3, 2'b11, 2'b11, 2'b11);
      idle(5, 2'b00, 2'b11, 2'b11);
      add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11);
      idle(2, 2'b00, 2'b00, 2'b11);
      add(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(2, 2'b00, 2'b00, 2'b00);
      // Reset in the middle of a ch1 qualification.
      repeat (3) add(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      repeat (2) add(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      idle(5, 2'b10, 2'b00, 2'b00);
      add(1'b1, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
      idle(2, 2'b10, 2'b10, 2'b10);

      rst_n = 1'b0;
      i_btn = 2'b00;
      i_clr = 2'b00;
      #12;
      chk("reset state",   {6'd0, o_state},   8'd0);
      chk("reset press",   {6'd0, o_press},   8'd0);
      chk("reset release", {6'd0, o_release}, 8'd0);
      chk("reset pending", {6'd0, o_pending}, 8'd0);
      chk("reset irq",     {7'd0, o_irq},     8'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n;
         i_btn = vecs[i].btn;
         i_clr = vecs[i].clr;
         if (!vecs[i].rst_n) begin
            #1;
            chk($sformatf("v%0d async reset state", i), {6'd0, o_state}, 8'd0);
            chk($sformatf("v%0d async reset irq", i),   {7'd0, o_irq},   8'd0);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d state", i),   {6'd0, o_state},   {6'd0, vecs[i].st});
         chk($sformatf("v%0d press", i),   {6'd0, o_press},   {6'd0, vecs[i].pr});
         chk($sformatf("v%0d release", i), {6'd0, o_release}, {6'd0, vecs[i].rl});
         chk($sformatf("v%0d pending", i), {6'd0, o_pending}, {6'd0, pexp(vecs[i].pd)});
         chk($sformatf("v%0d irq", i),     {7'd0, o_irq},     {7'd0, |pexp(vecs[i].pd)});
         chk($sformatf("v%0d press_and_release", i), {6'd0, o_press & o_release}, 8'd0);
      end

      // Release latency on ch1, measured with a bounded wait.
      i_btn = 2'b00;
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (o_release[1]) break;
      end
      chk("ch1 release latency", 8'(n), 8'd6);
      chk("ch1 state after release", {6'd0, o_state}, 8'd0);
      chk("ch1 release pulse width", {6'd0, o_release}, 8'd2);
      @(posedge clk);
      #1;
      chk("ch1 release pulse ends", {6'd0, o_release}, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter N, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter STABLE_CYCLES, default 50000: consecutive cycles an input must differ from o_state before o_state flips (2..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 16: per-channel counter width.
REQ-004 SHALL have parameter INIT, default all zeros: N-bit reset value of o_state.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_btn  input  N  raw asynchronous button levels, one per channel.
REQ-008 i_clr  input  N  per-channel pending-clear strobe (IRQ feature only).
REQ-009 o_state  output  N  debounced level per channel.
REQ-010 o_press  output  N  one-cycle pulse on a debounced 0->1 transition.
REQ-011 o_release  output  N  one-cycle pulse on a debounced 1->0 transition.
REQ-012 o_pending  output  N  sticky per-channel edge-seen flags (IRQ feature only).
REQ-013 o_irq  output  1  OR of o_pending.

Function
REQ-014 Each i_btn bit SHALL pass through a two-flop synchroniser before any other use.
REQ-015 Per channel: synchronised input equal to o_state -> counter SHALL clear to 0 in the same cycle.
REQ-016 Per channel: synchronised input differs and counter < STABLE_CYCLES-1 -> counter SHALL increment by 1.
REQ-017 Per channel: synchronised input differs and counter == STABLE_CYCLES-1 -> o_state SHALL toggle, counter SHALL clear, and o_press or o_release SHALL assert for exactly one cycle with the new o_state.
REQ-018 Latency: clean input step to o_state change SHALL be exactly 2 + STABLE_CYCLES clock cycles.
REQ-019 Any glitch shorter than STABLE_CYCLES synchronised cycles SHALL leave o_state and pulses unchanged and reset the counter.
REQ-020 Counters SHALL never wrap; the STABLE_CYCLES-1 compare guarantees saturation-free operation.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 o_press and o_release for the same channel SHALL never assert in the same cycle.

Reset
REQ-023 rst_n low SHALL asynchronously set: synchronisers to INIT, o_state = INIT, counters = 0, o_press = 0, o_release = 0, o_pending = 0, o_irq = 0.
REQ-024 Reset asserted mid-count SHALL discard the count; after release the full STABLE_CYCLES qualification restarts, no pulse emitted for the aborted transition.
REQ-025 No pulse SHALL be generated on reset release even if i_btn differs from INIT until qualified per REQ-017.

Configuration
REQ-026 Macro DEBOUNCE_IRQ_EN defined: o_pending[i] SHALL set on o_press[i] or o_release[i], clear on i_clr[i]; set wins when simultaneous; o_irq registered-free OR of o_pending.
REQ-027 Macro DEBOUNCE_IRQ_EN undefined: o_pending and o_irq SHALL be constant 0, i_clr ignored, no pending flops synthesised; ports unchanged.

Structure
REQ-028 Shared package debounce_pkg SHALL hold the default STABLE_CYCLES constant, default CNT_W and a clog2-based width check helper.
REQ-029 A sub-module debounce_chan SHALL implement one channel (synchroniser, counter, state, pulses); debounce_multi SHALL instantiate N copies via generate plus the IRQ logic.
REQ-030 Elaboration SHALL fail if STABLE_CYCLES > 2^CNT_W-1 or STABLE_CYCLES < 2.

Verification (bench uses N=2, STABLE_CYCLES=4, CNT_W=4, INIT=0, 10 ns clock)
REQ-031 i_btn[0] high for 1 cycle then low -> o_state stays 2'b00, no pulses.
REQ-032 i_btn[0] held high -> o_state[0] rises exactly 6 cycles after the step, o_press[0] high one cycle, o_release silent.
REQ-033 i_btn = 2'b11 step, later 2'b00 step -> both channels' press pulses in same cycle, later both release pulses in same cycle.
REQ-034 i_btn[1] high, rst_n pulsed low after 3 cycles -> all outputs 0 during reset; o_state[1] rises 6 cycles after rst_n release.
REQ-035 DEBOUNCE_IRQ_EN: press on ch0 -> o_pending=2'b01, o_irq=1; i_clr[0] in same cycle as new release pulse -> o_pending[0] stays 1; i_clr[0] alone -> o_pending=0, o_irq=0.
